// File: rtl/count_decoder_pkg.sv
// Shared types for the count-stream decoder: tracker states and per-sample step classes.
package count_decoder_pkg;

  typedef enum logic [1:0] {
    ST_UNSYNC  = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    STEP_UP   = 2'd0,
    STEP_DOWN = 2'd1,
    STEP_BAD  = 2'd2
  } step_e;

  // good_cnt width covers LOCK_N up to 15
  localparam int GOOD_CNT_W = 4;
  localparam int ERRCNT_W   = 8;

endpackage

// File: rtl/count_decoder_step_classifier.sv
// Combinational delta classifier: +1 (mod 2^WIDTH) is up, -1 is down, anything else is bad.
module step_classifier
  import count_decoder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] prev,
  input  logic [WIDTH-1:0] count_in,
  output step_e            step
);

  logic [WIDTH-1:0] delta;

  // Modular subtraction makes max->0 and 0->max single steps
  assign delta = count_in - prev;

  always_comb begin
    step = STEP_BAD;
    if (delta == WIDTH'(1)) begin
      step = STEP_UP;
    end else if (delta == {WIDTH{1'b1}}) begin
      step = STEP_DOWN;
    end
  end

endmodule

// File: rtl/count_decoder.sv
// Recovers direction and lock status from an observed up/down counter output.
// Optional COUNT_DECODER_ERRCNT_EN adds a saturating 8-bit loss-of-lock counter output err_count.
module count_decoder
  import count_decoder_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int RUN_W  = 8,
  parameter int LOCK_N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic             valid_in,
  output logic             dir_out,
  output logic             dir_valid,
  output logic             locked,
  output logic             err,
`ifdef COUNT_DECODER_ERRCNT_EN
  output logic [ERRCNT_W-1:0] err_count,
`endif
  output logic [RUN_W-1:0] run_len
);

  localparam logic [GOOD_CNT_W-1:0] LOCK_LAST = GOOD_CNT_W'(LOCK_N - 1);

  state_e                  state_q;
  logic [WIDTH-1:0]        prev_q;
  logic [GOOD_CNT_W-1:0]   good_cnt_q;
  logic                    last_dir_q;
  logic                    dir_q;
  logic                    dir_valid_q;
  logic                    locked_q;
  logic                    err_q;
  logic [RUN_W-1:0]        run_len_q;
  logic [RUN_W-1:0]        run_len_d;
  step_e                   step;
  logic                    step_up;
  logic                    step_bad;

  step_classifier #(
    .WIDTH(WIDTH)
  ) u_classifier (
    .prev    (prev_q),
    .count_in(count_in),
    .step    (step)
  );

  assign step_up  = (step == STEP_UP);
  assign step_bad = (step == STEP_BAD);

  // Run length restarts on a direction change or after a bad step (run_len_q == 0)
  always_comb begin
    run_len_d = run_len_q;
    if (step_bad) begin
      run_len_d = '0;
    end else if ((run_len_q == '0) || (last_dir_q != step_up)) begin
      run_len_d = RUN_W'(1);
    end else if (run_len_q != {RUN_W{1'b1}}) begin
      run_len_d = run_len_q + RUN_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_UNSYNC;
      prev_q      <= '0;
      good_cnt_q  <= '0;
      last_dir_q  <= 1'b0;
      dir_q       <= 1'b0;
      dir_valid_q <= 1'b0;
      locked_q    <= 1'b0;
      err_q       <= 1'b0;
      run_len_q   <= '0;
    end else begin
      dir_valid_q <= 1'b0;
      err_q       <= 1'b0;
      case (state_q)
        ST_UNSYNC: begin
          if (valid_in) begin
            prev_q     <= count_in;
            good_cnt_q <= '0;
            state_q    <= ST_ACQUIRE;
          end
        end
        ST_ACQUIRE: begin
          if (valid_in) begin
            prev_q <= count_in;
            if (step_bad) begin
              good_cnt_q <= '0;
              run_len_q  <= '0;
            end else begin
              run_len_q  <= run_len_d;
              last_dir_q <= step_up;
              if (good_cnt_q == LOCK_LAST) begin
                good_cnt_q  <= '0;
                state_q     <= ST_LOCKED;
                locked_q    <= 1'b1;
                dir_q       <= step_up;
                dir_valid_q <= 1'b1;
              end else begin
                good_cnt_q <= good_cnt_q + GOOD_CNT_W'(1);
              end
            end
          end
        end
        ST_LOCKED: begin
          if (valid_in) begin
            prev_q <= count_in;
            if (step_bad) begin
              state_q   <= ST_FAULT;
              err_q     <= 1'b1;
              locked_q  <= 1'b0;
              run_len_q <= '0;
            end else begin
              dir_q       <= step_up;
              dir_valid_q <= 1'b1;
              last_dir_q  <= step_up;
              run_len_q   <= run_len_d;
            end
          end
        end
        ST_FAULT: begin
          // One-cycle error state; reacquisition starts from scratch
          good_cnt_q <= '0;
          state_q    <= ST_ACQUIRE;
          if (valid_in) begin
            prev_q <= count_in;
          end
        end
        default: begin
          state_q <= ST_UNSYNC;
        end
      endcase
    end
  end

`ifdef COUNT_DECODER_ERRCNT_EN
  logic [ERRCNT_W-1:0] err_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_cnt_q <= '0;
    end else if ((state_q == ST_LOCKED) && valid_in && step_bad &&
                 (err_cnt_q != {ERRCNT_W{1'b1}})) begin
      err_cnt_q <= err_cnt_q + ERRCNT_W'(1);
    end
  end

  assign err_count = err_cnt_q;
`endif

  assign dir_out   = dir_q;
  assign dir_valid = dir_valid_q;
  assign locked    = locked_q;
  assign err       = err_q;
  assign run_len   = run_len_q;

endmodule
